// File: rtl/bus_map_pkg.sv
// -----------------------------------------------------------------------------
// bus_map_pkg
//   Shared processor-bus map: peripheral base addresses, register offsets of the
//   millisecond timer, its interrupt line index, CTRL bit positions and the
//   interrupt-request state type.
//   No ports (package).
// -----------------------------------------------------------------------------
package bus_map_pkg;

    // Timer block occupies TIMER_BASE .. TIMER_BASE+3
    localparam logic [7:0] TIMER_BASE   = 8'hF0;

    // Register offsets inside the timer block
    localparam logic [1:0] TMR_COUNT    = 2'd0;
    localparam logic [1:0] TMR_INTERVAL = 2'd1;
    localparam logic [1:0] TMR_CLEAR    = 2'd2;
    localparam logic [1:0] TMR_CTRL     = 2'd3;

    // Processor interrupt line driven by the timer
    localparam int TIMER_IRQ = 1;

    // CTRL register bit positions (read view: {5'b0, OVERRUN, PENDING, IRQ_EN})
    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_PENDING_BIT = 1;
    localparam int CTRL_OVERRUN_BIT = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        RAISED = 1'b1
    } irq_state_t;

    // Assemble the CTRL read value from its three status flags.
    function automatic logic [7:0] ctrl_word(input logic irq_en,
                                             input logic pending,
                                             input logic overrun);
        logic [7:0] w;
        w = 8'h00;
        w[CTRL_IRQ_EN_BIT]  = irq_en;
        w[CTRL_PENDING_BIT] = pending;
        w[CTRL_OVERRUN_BIT] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides CLK down to a one-cycle tick every TICK_DIV cycles. The divider
//   counts 0..TICK_DIV-1; tick is high while it sits on TICK_DIV-1.
//   Ports:
//     CLK    in   system clock
//     RESET  in   synchronous active-high reset (divider -> 0)
//     clr    in   synchronous clear of the divider, overrides wrap/increment
//     tick   out  one-cycle pulse when the divider is at its last value
// -----------------------------------------------------------------------------
module tick_prescaler
    import bus_map_pkg::*;
#(
    parameter int TICK_DIV = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// -----------------------------------------------------------------------------
// bus_timer
//   Memory-mapped millisecond timer on the 8-bit processor bus. Counts ms
//   ticks in COUNT, fires an interrupt every INTERVAL ms and holds it until
//   the processor acknowledges. Registers are read back on the shared
//   tri-state data bus with one cycle of latency.
//   Register map (offset from BASE_ADDR):
//     +0 COUNT     R    free-running ms counter, wraps 255 -> 0
//     +1 INTERVAL  R/W  ms between interrupts, 0 disables event generation
//     +2 CLEAR     W    any write zeroes prescaler, COUNT and interval counter
//     +3 CTRL      R/W  W: bit0 IRQ_EN, clears OVERRUN
//                       R: {5'b0, OVERRUN, PENDING, IRQ_EN}
//   Ports:
//     CLK                  in     system clock
//     RESET                in     synchronous active-high reset
//     BUS_DATA             inout  shared data bus, driven only for our reads
//     BUS_ADDR             in     bus address
//     BUS_WE               in     1 = write cycle, 0 = read/idle
//     BUS_INTERRUPT_RAISE  out    registered interrupt request
//     BUS_INTERRUPT_ACK    in     interrupt acknowledge from the processor
// -----------------------------------------------------------------------------
module bus_timer
    import bus_map_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR     = TIMER_BASE,
    parameter int         TICK_DIV      = 100000,
    parameter logic [7:0] INIT_INTERVAL = 8'd100
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    // ---------------------------------------------------------------- decode
    logic [7:0] offset;
    logic       in_range;
    logic [1:0] reg_sel;
    logic       rd_hit;
    logic       clr_wr;
    logic       ivl_wr;
    logic       ctrl_wr;

    // Subtracting the base keeps the decode correct for unaligned bases.
    assign offset   = BUS_ADDR - BASE_ADDR;
    assign in_range = (offset[7:2] == 6'd0);
    assign reg_sel  = offset[1:0];
    assign rd_hit   = in_range && !BUS_WE;
    assign clr_wr   = in_range && BUS_WE && (reg_sel == TMR_CLEAR);
    assign ivl_wr   = in_range && BUS_WE && (reg_sel == TMR_INTERVAL);
    assign ctrl_wr  = in_range && BUS_WE && (reg_sel == TMR_CTRL);

    // ------------------------------------------------------------- prescaler
    logic tick;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (clr_wr),
        .tick  (tick)
    );

    // ------------------------------------------------- counters and registers
    logic [7:0] count_q,    count_d;
    logic [7:0] interval_q, interval_d;
    logic [7:0] ivl_cnt_q,  ivl_cnt_d;
    logic       irq_en_q,   irq_en_d;
    logic       ivl_last;
    logic       event_p;
    logic       fire;

    assign ivl_last = (ivl_cnt_q == interval_q - 8'd1);

    // A CLEAR or INTERVAL write on a tick edge restarts the interval count,
    // so the event that tick would have produced is suppressed as well.
    assign event_p = tick && !clr_wr && !ivl_wr && (interval_q != 8'd0) && ivl_last;
    assign fire    = event_p && irq_en_q;

    always_comb begin
        count_d    = count_q;
        interval_d = interval_q;
        ivl_cnt_d  = ivl_cnt_q;
        irq_en_d   = irq_en_q;

        if (clr_wr) begin
            count_d   = 8'd0;
            ivl_cnt_d = 8'd0;
        end else if (tick) begin
            count_d = count_q + 8'd1;
            if (interval_q != 8'd0) begin
                ivl_cnt_d = ivl_last ? 8'd0 : ivl_cnt_q + 8'd1;
            end
        end

        if (ivl_wr) begin
            interval_d = BUS_DATA;
            ivl_cnt_d  = 8'd0;
        end

        if (ctrl_wr) begin
            irq_en_d = BUS_DATA[CTRL_IRQ_EN_BIT];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q    <= 8'd0;
            interval_q <= INIT_INTERVAL;
            ivl_cnt_q  <= 8'd0;
            irq_en_q   <= 1'b1;
        end else begin
            count_q    <= count_d;
            interval_q <= interval_d;
            ivl_cnt_q  <= ivl_cnt_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // ---------------------------------------------------------------- IRQ FSM
    irq_state_t state_q;
    logic       raise_q;
    logic       overrun_q;

    // An event arriving together with ACK keeps the request raised (set wins);
    // with IRQ_EN low, events are dropped and cannot hold off an ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            raise_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_q <= RAISED;
                        raise_q <= 1'b1;
                    end
                end
                RAISED: begin
                    if (!fire && BUS_INTERRUPT_ACK) begin
                        state_q <= IDLE;
                        raise_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    raise_q <= 1'b0;
                end
            endcase

            // A lost event in the same cycle as a CTRL write still records.
            if ((state_q == RAISED) && fire && !BUS_INTERRUPT_ACK) begin
                overrun_q <= 1'b1;
            end else if (ctrl_wr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign BUS_INTERRUPT_RAISE = raise_q;

    // ----------------------------------------------------- read path / driver
    logic [7:0] rd_mux;
    logic [7:0] rd_data_q;
    logic       rd_oe_q;

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            TMR_COUNT:    rd_mux = count_q;
            TMR_INTERVAL: rd_mux = interval_q;
            TMR_CTRL:     rd_mux = ctrl_word(irq_en_q, state_q == RAISED, overrun_q);
            default:      rd_mux = 8'h00;
        endcase
    end

    // NOTE: the read-data latch is reset along with its enable so no stale
    // value from before reset can ever reach the bus.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_oe_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            rd_oe_q <= rd_hit;
            if (rd_hit) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign BUS_DATA = rd_oe_q ? rd_data_q : 8'hZZ;

endmodule

// File: tb/tb_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_bus_timer
//   Self-checking bench for bus_timer (TICK_DIV=4, BASE_ADDR=8'hF0). A
//   behavioural model predicts bus readback and the interrupt line per cycle;
//   predictions go into queues that an independent negedge monitor drains.
// -----------------------------------------------------------------------------
module tb_bus_timer;
    import bus_map_pkg::*;

    localparam int         DIV  = 4;
    localparam logic [7:0] BASE = 8'hF0;
    localparam logic [7:0] INIT = 8'd100;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_ACK;
    logic       BUS_INTERRUPT_RAISE;
    wire  [7:0] bus_data;
    logic       tb_oe;
    logic [7:0] tb_drv;

    assign bus_data = tb_oe ? tb_drv : 8'hZZ;

    bus_timer #(
        .BASE_ADDR     (BASE),
        .TICK_DIV      (DIV),
        .INIT_INTERVAL (INIT)
    ) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .BUS_DATA            (bus_data),
        .BUS_ADDR            (BUS_ADDR),
        .BUS_WE              (BUS_WE),
        .BUS_INTERRUPT_RAISE (BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK   (BUS_INTERRUPT_ACK)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef struct packed {
        logic oe;
        logic raise;
    } exp_t;

    exp_t       cyc_q[$];
    logic [7:0] rd_q[$];

    int m_presc, m_count, m_interval, m_ivl;
    bit m_irq_en, m_raised, m_overrun, m_oe;

    function automatic logic [7:0] m_reg(input logic [1:0] o);
        case (o)
            2'd0:    return 8'(m_count);
            2'd1:    return 8'(m_interval);
            2'd3:    return {5'b0, m_overrun, m_raised, m_irq_en};
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model across one clock edge with the given bus inputs.
    task automatic model_step(input bit rst, input logic [7:0] addr, input bit we,
                              input logic [7:0] wd, input bit ack);
        logic [7:0] off;
        bit hit, tick, clr, iw, cw, fire;
        if (rst) begin
            m_presc = 0; m_count = 0; m_interval = int'(INIT); m_ivl = 0;
            m_irq_en = 1; m_raised = 0; m_overrun = 0; m_oe = 0;
            return;
        end
        off  = addr - BASE;
        hit  = (off < 8'd4);
        clr  = hit && we && (off == 8'd2);
        iw   = hit && we && (off == 8'd1);
        cw   = hit && we && (off == 8'd3);
        m_oe = hit && !we;
        if (m_oe) rd_q.push_back(m_reg(off[1:0]));

        tick = (m_presc == DIV - 1);
        fire = tick && !clr && !iw && (m_interval != 0)
               && ((m_ivl + 1) % m_interval == 0) && m_irq_en;

        m_presc = clr ? 0 : (m_presc + 1) % DIV;
        if (clr) begin
            m_count = 0;
            m_ivl   = 0;
        end else if (tick) begin
            m_count = (m_count + 1) % 256;
            if (m_interval != 0) m_ivl = (m_ivl + 1) % m_interval;
        end
        if (iw) begin
            m_interval = int'(wd);
            m_ivl      = 0;
        end

        if (m_raised && fire && !ack) m_overrun = 1;
        else if (cw)                  m_overrun = 0;
        if (cw) m_irq_en = wd[0];

        if (!m_raised)         m_raised = fire;
        else if (ack && !fire) m_raised = 0;
    endtask

    // ----------------------------------------------------------------- driver
    bit last_rd = 0;

    task automatic step(input bit rst, input logic [7:0] addr, input bit we,
                        input logic [7:0] wd, input bit ack);
        exp_t e;
        logic [7:0] off;
        RESET             = rst;
        BUS_ADDR          = addr;
        BUS_WE            = we;
        tb_drv            = wd;
        tb_oe             = we;
        BUS_INTERRUPT_ACK = ack;
        model_step(rst, addr, we, wd, ack);
        e.oe    = m_oe;
        e.raise = m_raised;
        cyc_q.push_back(e);
        off     = addr - BASE;
        last_rd = !rst && !we && (off < 8'd4);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'h00, 0, 8'h00, 0);
    endtask

    // The cycle after one of our reads the timer still drives the bus, so a
    // write never directly follows a read.
    task automatic wr_addr(input logic [7:0] addr, input logic [7:0] d);
        if (last_rd) idle(1);
        step(0, addr, 1, d, 0);
    endtask

    task automatic wr(input logic [1:0] o, input logic [7:0] d);
        wr_addr(BASE + 8'(o), d);
    endtask

    task automatic rd(input logic [1:0] o);
        step(0, BASE + 8'(o), 0, 8'h00, 0);
    endtask

    // ---------------------------------------------------------------- monitor
    exp_t       mon_e;
    logic [7:0] mon_d;
    logic       mon_drv;

    always @(negedge CLK) begin
        if (cyc_q.size() != 0) begin
            mon_e = cyc_q.pop_front();
            check("raise", {7'b0, BUS_INTERRUPT_RAISE}, {7'b0, mon_e.raise});
            if (!tb_oe) begin
                mon_drv = (bus_data !== 8'hZZ);
                check("drive_en", {7'b0, mon_drv}, {7'b0, mon_e.oe});
                if (mon_drv) begin
                    if (rd_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_unexpected: bus driven with %h, no read outstanding", bus_data);
                    end else begin
                        mon_d = rd_q.pop_front();
                        check("rd_data", bus_data, mon_d);
                    end
                end
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    int  raise_cycles;
    bit  seen;
    logic drv_now;

    initial begin
        tb_oe = 0;
        tb_drv = 8'h00;

        // 1: reset, 40 idle cycles -> COUNT = 10 ms; release off-range
        step(1, 8'h00, 0, 8'h00, 0);
        step(1, 8'h00, 0, 8'h00, 0);
        check("t1_raise_reset", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
        drv_now = (bus_data !== 8'hZZ);
        check("t1_bus_z_reset", {7'b0, drv_now}, 8'h00);
        idle(40);
        rd(TMR_COUNT);
        check("t1_count", bus_data, 8'h0A);
        idle(1);
        drv_now = (bus_data !== 8'hZZ);
        check("t1_release", {7'b0, drv_now}, 8'h00);

        // 2: INTERVAL=3 -> raise after 3 ticks, held until ACK
        wr(TMR_CLEAR, 8'h00);
        wr(TMR_INTERVAL, 8'h03);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            idle(1);
            seen = BUS_INTERRUPT_RAISE;
        end
        check("t2_raise_seen", {7'b0, seen}, 8'h01);
        idle(2);
        check("t2_raise_held", {7'b0, BUS_INTERRUPT_RAISE}, 8'h01);
        step(0, 8'h00, 0, 8'h00, 1);
        check("t2_raise_ack", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);

        // 3: INTERVAL=1, no ACK for several ticks -> OVERRUN set, then cleared
        wr(TMR_CLEAR, 8'h00);
        wr(TMR_INTERVAL, 8'h01);
        idle(15);
        rd(TMR_CTRL);
        check("t3_ctrl_overrun", bus_data, 8'h07);
        wr(TMR_CTRL, 8'h01);
        rd(TMR_CTRL);
        check("t3_ctrl_cleared", bus_data, 8'h03);

        // 4: EVENT and ACK on the same edge keep the request; lone ACK drops it
        idle(3);
        step(0, 8'h00, 0, 8'h00, 1);
        check("t4_event_ack", {7'b0, BUS_INTERRUPT_RAISE}, 8'h01);
        step(0, 8'h00, 0, 8'h00, 1);
        check("t4_ack", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);

        // 5: CLEAR mid-count, then INTERVAL=0 never raises
        idle(2);
        wr(TMR_CLEAR, 8'h00);
        rd(TMR_COUNT);
        check("t5_count_clear", bus_data, 8'h00);
        wr(TMR_INTERVAL, 8'h00);
        step(0, 8'h00, 0, 8'h00, 1);
        raise_cycles = 0;
        for (int i = 0; i < 1000; i++) begin
            idle(1);
            if (BUS_INTERRUPT_RAISE) raise_cycles++;
        end
        check("t5_no_raise", 8'(raise_cycles), 8'h00);

        // 6: RESET while raised and mid-read
        wr(TMR_INTERVAL, 8'h01);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            idle(1);
            seen = BUS_INTERRUPT_RAISE;
        end
        check("t6_raise_seen", {7'b0, seen}, 8'h01);
        rd(TMR_INTERVAL);
        step(1, BASE + 8'(TMR_INTERVAL), 0, 8'h00, 0);
        check("t6_raise_reset", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
        drv_now = (bus_data !== 8'hZZ);
        check("t6_bus_z", {7'b0, drv_now}, 8'h00);
        rd(TMR_INTERVAL);
        check("t6_interval_init", bus_data, INIT);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] o;
            r = int'($urandom_range(0, 99));
            o = 2'($urandom_range(0, 3));
            if (r < 2) begin
                step(1, BASE, 0, 8'h00, 0);
            end else if (r < 30) begin
                rd(o);
            end else if (r < 45) begin
                if (o == TMR_INTERVAL) wr(o, 8'($urandom_range(0, 4)));
                else                   wr(o, 8'($urandom));
            end else if (r < 52) begin
                step(0, 8'($urandom), 0, 8'h00, 0);
            end else if (r < 55) begin
                wr_addr(8'($urandom), 8'($urandom));
            end else begin
                step(0, 8'h00, 0, 8'h00, $urandom_range(0, 3) == 0);
            end
        end

        idle(2);
        @(negedge CLK);
        #1;
        check("rd_queue_drained", 8'(rd_q.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
